// File: rtl/logicnet_pkg.sv
// Shared types and helpers for LogicNet LUT layers: FSM states,
// table address width and packed-bus slicing.
package logicnet_pkg;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  function automatic int addr_w(input int fan_in, input int in_bits);
    return fan_in * in_bits;
  endfunction

  // LSB position of element idx in a bus of equally sized fields.
  function automatic int pack_lsb(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/logicnet_lut_ram.sv
// One neuron truth table: synchronous write, asynchronous read,
// shaped for distributed RAM.
module logicnet_lut_ram #(
  parameter int ADDR_W   = 6,
  parameter int OUT_BITS = 2
) (
  input  logic                clk,
  input  logic                we,
  input  logic [ADDR_W-1:0]   waddr,
  input  logic [OUT_BITS-1:0] wdata,
  input  logic [ADDR_W-1:0]   raddr,
  output logic [OUT_BITS-1:0] rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [OUT_BITS-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/logicnet_lut_layer.sv
// Runtime-programmable LogicNet neuron layer: parallel table lookups with a
// clear sweep FSM, config write port and a registered 2-entry output buffer.
module logicnet_lut_layer
  import logicnet_pkg::*;
#(
  parameter  int N_NEURONS = 8,
  parameter  int FAN_IN    = 3,
  parameter  int IN_BITS   = 2,
  parameter  int OUT_BITS  = 2,
  localparam int ADDR_W    = addr_w(FAN_IN, IN_BITS),
  localparam int NEU_W     = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clr_tables,
  input  logic                          cfg_we,
  input  logic [NEU_W-1:0]              cfg_neuron,
  input  logic [ADDR_W-1:0]             cfg_addr,
  input  logic [OUT_BITS-1:0]           cfg_data,
  output logic                          cfg_ready,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [N_NEURONS*ADDR_W-1:0]   in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [N_NEURONS*OUT_BITS-1:0] out_data
);

  localparam int                DEPTH    = 2 ** ADDR_W;
  localparam int                WORD_W   = N_NEURONS * OUT_BITS;
  localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(DEPTH - 1);

  state_e              state_r, state_n;
  logic [ADDR_W-1:0]   clr_addr_r, clr_addr_n;
  logic [WORD_W-1:0]   head_r, head_n;
  logic                head_valid_r, head_valid_n;
  logic [WORD_W-1:0]   skid_r, skid_n;
  logic                skid_valid_r, skid_valid_n;
  logic                in_ready_r, in_ready_n;
  logic                cfg_ready_r, cfg_ready_n;

  logic                clearing_s;
  logic                cfg_acc_s;
  logic                push_s;
  logic                pop_s;
  logic [WORD_W-1:0]   lookup_word_s;

  assign clearing_s = (state_r == ST_CLEAR);
  assign cfg_acc_s  = cfg_we & cfg_ready_r;
  assign push_s     = in_valid & in_ready_r;
  assign pop_s      = head_valid_r & out_ready;

  // Sweep writes zero everywhere; otherwise only the addressed neuron is written.
  for (genvar i = 0; i < N_NEURONS; i++) begin : g_neuron
    logic                we_s;
    logic [ADDR_W-1:0]   waddr_s;
    logic [OUT_BITS-1:0] wdata_s;
    logic [OUT_BITS-1:0] rdata_s;

    assign we_s    = clearing_s | (cfg_acc_s & (cfg_neuron == NEU_W'(i)));
    assign waddr_s = clearing_s ? clr_addr_r : cfg_addr;
    assign wdata_s = clearing_s ? {OUT_BITS{1'b0}} : cfg_data;

    logicnet_lut_ram #(
      .ADDR_W   (ADDR_W),
      .OUT_BITS (OUT_BITS)
    ) u_ram (
      .clk   (clk),
      .we    (we_s),
      .waddr (waddr_s),
      .wdata (wdata_s),
      .raddr (in_data[pack_lsb(i, ADDR_W) +: ADDR_W]),
      .rdata (rdata_s)
    );

    assign lookup_word_s[pack_lsb(i, OUT_BITS) +: OUT_BITS] = rdata_s;
  end

  always_comb begin
    state_n      = state_r;
    clr_addr_n   = clr_addr_r;
    head_n       = head_r;
    head_valid_n = head_valid_r;
    skid_n       = skid_r;
    skid_valid_n = skid_valid_r;

    case (state_r)
      ST_CLEAR: begin
        if (clr_addr_r == CLR_LAST) begin
          state_n    = ST_RUN;
          clr_addr_n = {ADDR_W{1'b0}};
        end else begin
          state_n    = ST_CLEAR;
          clr_addr_n = clr_addr_r + ADDR_W'(1);
        end
      end
      ST_RUN: begin
        if (clr_tables) begin
          state_n      = ST_CLEAR;
          clr_addr_n   = {ADDR_W{1'b0}};
          head_valid_n = 1'b0;
          skid_valid_n = 1'b0;
        end else if (pop_s) begin
          // Head leaves: skid (if any) moves up, a new word refills behind it.
          if (skid_valid_r) begin
            head_n       = skid_r;
            head_valid_n = 1'b1;
            skid_valid_n = push_s;
            skid_n       = push_s ? lookup_word_s : skid_r;
          end else if (push_s) begin
            head_n       = lookup_word_s;
            head_valid_n = 1'b1;
          end else begin
            head_valid_n = 1'b0;
          end
        end else if (push_s) begin
          if (head_valid_r) begin
            skid_n       = lookup_word_s;
            skid_valid_n = 1'b1;
          end else begin
            head_n       = lookup_word_s;
            head_valid_n = 1'b1;
          end
        end else begin
          head_valid_n = head_valid_r;
          skid_valid_n = skid_valid_r;
        end
      end
      default: begin
        state_n      = ST_CLEAR;
        clr_addr_n   = {ADDR_W{1'b0}};
        head_valid_n = 1'b0;
        skid_valid_n = 1'b0;
      end
    endcase

    cfg_ready_n = (state_n == ST_RUN);
    in_ready_n  = (state_n == ST_RUN) & ~(head_valid_n & skid_valid_n);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_CLEAR;
      clr_addr_r   <= {ADDR_W{1'b0}};
      head_r       <= {WORD_W{1'b0}};
      head_valid_r <= 1'b0;
      skid_r       <= {WORD_W{1'b0}};
      skid_valid_r <= 1'b0;
      in_ready_r   <= 1'b0;
      cfg_ready_r  <= 1'b0;
    end else begin
      state_r      <= state_n;
      clr_addr_r   <= clr_addr_n;
      head_r       <= head_n;
      head_valid_r <= head_valid_n;
      skid_r       <= skid_n;
      skid_valid_r <= skid_valid_n;
      in_ready_r   <= in_ready_n;
      cfg_ready_r  <= cfg_ready_n;
    end
  end

  assign cfg_ready = cfg_ready_r;
  assign in_ready  = in_ready_r;
  assign out_valid = head_valid_r;
  assign out_data  = head_r;

endmodule

// File: tb/tb_logicnet_lut_layer.sv
// Self-checking bench for logicnet_lut_layer: directed vector table, multi-cycle
// corner sequences and a randomized run against a behavioural table/queue model.
module tb_logicnet_lut_layer;

  localparam int N     = 8;
  localparam int AW    = 6;
  localparam int OB    = 2;
  localparam int DEPTH = 64;
  localparam int WW    = N * OB;
  localparam int IW    = N * AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clr_tables = 1'b0;
  logic          cfg_we = 1'b0;
  logic [2:0]    cfg_neuron = 3'd0;
  logic [AW-1:0] cfg_addr = 6'd0;
  logic [OB-1:0] cfg_data = 2'd0;
  logic          cfg_ready;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [IW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [WW-1:0] out_data;

  logicnet_lut_layer dut (
    .clk        (clk),
    .rst        (rst),
    .clr_tables (clr_tables),
    .cfg_we     (cfg_we),
    .cfg_neuron (cfg_neuron),
    .cfg_addr   (cfg_addr),
    .cfg_data   (cfg_data),
    .cfg_ready  (cfg_ready),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: table contents, queue of words owed downstream,
  // remaining clear-sweep cycles, and the last word handed off.
  logic [OB-1:0] tbl [N][DEPTH];
  logic [WW-1:0] q [$];
  int            clear_left = DEPTH;
  logic [WW-1:0] last_word = '0;
  bit            last_known = 1'b0;
  bit            model_on = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 30) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [WW-1:0] ref_lookup(input logic [IW-1:0] d);
    logic [WW-1:0] r = '0;
    for (int i = 0; i < N; i++) r[i*OB +: OB] = tbl[i][d[i*AW +: AW]];
    return r;
  endfunction

  task automatic zero_tables();
    for (int i = 0; i < N; i++)
      for (int a = 0; a < DEPTH; a++) tbl[i][a] = '0;
  endtask

  // Check current outputs against the model, advance the model across the
  // coming edge using the inputs now driven, then step to just after the edge.
  task automatic cycle();
    bit acc;
    logic [WW-1:0] w;
    if (model_on) begin
      check("cfg_ready", 64'(cfg_ready), 64'(clear_left == 0));
      check("in_ready", 64'(in_ready), 64'(clear_left == 0 && q.size() < 2));
      check("out_valid", 64'(out_valid), 64'(q.size() != 0));
      if (q.size() != 0) check("out_data", 64'(out_data), 64'(q[0]));
      else if (last_known) check("out_data_idle", 64'(out_data), 64'(last_word));
    end
    if (rst) begin
      q.delete();
      clear_left = DEPTH;
      zero_tables();
      last_word  = '0;
      last_known = 1'b1;
      model_on   = 1'b1;
    end else if (clear_left > 0) begin
      clear_left--;
    end else begin
      acc = in_valid && (q.size() < 2);
      w   = ref_lookup(in_data);
      if (out_ready && q.size() != 0) begin
        last_word  = q.pop_front();
        last_known = 1'b1;
      end
      if (acc) q.push_back(w);
      if (cfg_we && cfg_neuron < N) tbl[cfg_neuron][cfg_addr] = cfg_data;
      if (clr_tables) begin
        q.delete();
        clear_left = DEPTH;
        zero_tables();
        last_known = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input int n, input int a, input int d);
    cfg_we = 1'b1; cfg_neuron = 3'(n); cfg_addr = 6'(a); cfg_data = 2'(d);
    cycle();
    cfg_we = 1'b0;
  endtask

  task automatic wait_cfg_ready(input string name);
    int n = 0;
    while (!cfg_ready && n < 200) begin
      cycle();
      n++;
    end
    check(name, 64'(n), 64'd64);
  endtask

  typedef struct {
    logic [IW-1:0] din;
    logic [WW-1:0] exp;
  } vec_t;

  vec_t vecs [5];

  initial begin
    vecs[0] = '{48'h0000_0000_048A, 16'h0007};  // n0@0x0A=3, n1@0x12=1
    vecs[1] = '{48'h0000_0000_0292, 16'h0000};  // swapped addresses miss
    vecs[2] = '{48'h0000_0000_0480, 16'h0004};  // n1 hit only
    vecs[3] = '{48'h2800_0000_000A, 16'h0003};  // n0 hit, n7@0x0A unprogrammed
    vecs[4] = '{48'hFC00_0000_0000, 16'h8000};  // n7@0x3F top address

    // Reset state
    cycle();
    cycle();
    check("rst_cfg_ready", 64'(cfg_ready), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);

    // Clear sweep length, then an arbitrary lookup reads zero
    rst = 1'b0;
    wait_cfg_ready("clear_cycles");
    in_valid = 1'b1; in_data = 48'h1234_5678_9ABC;
    cycle();
    in_valid = 1'b0;
    check("zero_lookup", 64'(out_data), 64'd0);
    cycle();

    // Program and table-driven lookups
    cfg_write(0, 6'h0A, 3);
    cfg_write(1, 6'h12, 1);
    cfg_write(7, 6'h3F, 2);
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1; in_data = vecs[k].din;
      cycle();
      in_valid = 1'b0;
      check("vec_valid", 64'(out_valid), 64'd1);
      check("vec_data", 64'(out_data), 64'(vecs[k].exp));
    end
    cycle();

    // Backpressure: two accepts fill the buffer, head held, then drained in order
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = vecs[0].din; cycle();
    in_data = vecs[4].din; cycle();
    in_data = vecs[3].din;
    check("bp_in_ready_low", 64'(in_ready), 64'd0);
    cycle();
    check("bp_hold1", 64'(out_data), 64'(vecs[0].exp));
    cycle();
    check("bp_hold2", 64'(out_data), 64'(vecs[0].exp));
    out_ready = 1'b1;
    cycle();
    check("bp_order1", 64'(out_data), 64'(vecs[4].exp));
    cycle();
    in_valid = 1'b0;
    check("bp_order2", 64'(out_data), 64'(vecs[3].exp));
    cycle();
    check("bp_drained", 64'(out_valid), 64'd0);

    // Same-cycle write and lookup of one entry
    cfg_write(2, 5, 1);
    cfg_we = 1'b1; cfg_neuron = 3'd2; cfg_addr = 6'd5; cfg_data = 2'b10;
    in_valid = 1'b1; in_data = 48'h0000_0000_5000;
    cycle();
    cfg_we = 1'b0;
    check("collide_old", 64'(out_data[5:4]), 64'd1);
    cycle();
    in_valid = 1'b0;
    check("collide_new", 64'(out_data[5:4]), 64'd2);
    cycle();

    // clr_tables with two buffered words
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = vecs[0].din; cycle();
    in_data = vecs[4].din; cycle();
    in_valid = 1'b0; clr_tables = 1'b1;
    cycle();
    clr_tables = 1'b0; out_ready = 1'b1;
    check("clr_out_valid", 64'(out_valid), 64'd0);
    begin
      int n = 0;
      while (!in_ready && n < 200) begin cycle(); n++; end
      check("clr_cycles", 64'(n), 64'd64);
    end
    in_valid = 1'b1; in_data = vecs[0].din; cycle();
    check("clr_zero_a", 64'(out_data), 64'd0);
    in_data = vecs[4].din; cycle();
    in_valid = 1'b0;
    check("clr_zero_b", 64'(out_data), 64'd0);
    cycle();

    // Reset with a non-empty buffer
    cfg_write(3, 9, 3);
    out_ready = 1'b0; in_valid = 1'b1; in_data = 48'h0000_0024_0000;
    cycle(); cycle();
    in_valid = 1'b0; rst = 1'b1;
    cycle();
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_out_data", 64'(out_data), 64'd0);
    rst = 1'b0; out_ready = 1'b1;
    wait_cfg_ready("midrst_cycles");

    // Randomized regression against the model
    for (int c = 0; c < 10000; c++) begin
      in_valid = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 0) begin
        in_data = {$urandom, $urandom};
      end else begin
        for (int i = 0; i < N; i++) in_data[i*AW +: AW] = 6'($urandom_range(0, 7));
      end
      cfg_we     = ($urandom_range(0, 2) == 0);
      cfg_neuron = 3'($urandom);
      cfg_addr   = 6'($urandom_range(0, 7));
      cfg_data   = 2'($urandom);
      out_ready  = ($urandom_range(0, 3) != 0);
      clr_tables = ($urandom_range(0, 999) == 0);
      rst        = ($urandom_range(0, 2999) == 0);
      cycle();
    end
    rst = 1'b0; clr_tables = 1'b0; cfg_we = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
